// File: rtl/mp3_huff_pkg.sv
// Shared types and constants for the MP3 Huffman main-data stages.
// Ports: none (package only).
// Holds the granule geometry, the collector state enum and the table-select type.
package mp3_huff_pkg;

  localparam int GRANULE_LINES  = 576;
  localparam int MAX_BIG_VALUES = 288;

  typedef enum logic [1:0] {
    IDLE,
    BIG,
    FILL
  } coll_state_t;

  typedef logic [4:0] huff_tbl_t;

endpackage

// File: rtl/huff_line_collector_if.sv
// Bundle of granule setup, decoded-pair input and line-indexed output signals.
// Ports: none; slave modport is the collector side, master modport is the driver side.
// Scalar clock and reset are kept outside the bundle.
interface huff_line_collector_if
  import mp3_huff_pkg::*;
#(
  parameter int VAL_W = 16
);

  logic                    start;
  logic [8:0]              big_values;
  logic [9:0]              region1_start;
  logic [9:0]              region2_start;
  huff_tbl_t               table_select0;
  huff_tbl_t               table_select1;
  huff_tbl_t               table_select2;
  logic                    axiiv;
  logic signed [VAL_W-1:0] x_val;
  logic signed [VAL_W-1:0] y_val;

  logic                    huff_en;
  huff_tbl_t               table_sel;
  logic                    axiov;
  logic [9:0]              line_idx;
  logic signed [VAL_W-1:0] x_out;
  logic signed [VAL_W-1:0] y_out;
  logic                    granule_done;
  logic                    err;

  modport slave (
    input  start, big_values, region1_start, region2_start,
           table_select0, table_select1, table_select2, axiiv, x_val, y_val,
    output huff_en, table_sel, axiov, line_idx, x_out, y_out, granule_done, err
  );

  modport master (
    output start, big_values, region1_start, region2_start,
           table_select0, table_select1, table_select2, axiiv, x_val, y_val,
    input  huff_en, table_sel, axiov, line_idx, x_out, y_out, granule_done, err
  );

endinterface

// File: rtl/huff_region_sel.sv
// Maps a frequency line to the Huffman table of the region it falls in.
// Ports: line_num, region starts and three candidate tables in; selected table out.
// Purely combinational; an inverted region2/region1 pair leaves region 1 empty.
module huff_region_sel
  import mp3_huff_pkg::*;
(
  input  logic [9:0] line_num,
  input  logic [9:0] region1_start,
  input  logic [9:0] region2_start,
  input  huff_tbl_t  tbl0,
  input  huff_tbl_t  tbl1,
  input  huff_tbl_t  tbl2,
  output huff_tbl_t  tbl
);

  always_comb begin
    if (line_num < region1_start) begin
      tbl = tbl0;
    end else if (line_num < region2_start) begin
      tbl = tbl1;
    end else begin
      tbl = tbl2;
    end
  end

endmodule

// File: rtl/huff_line_collector.sv
// Collects decoded big_values pairs of a granule and emits all lines, zero-filling the tail.
// Ports: clk, rst_n (sync, active-low), bus (slave): start/params, pair input, beat output, err.
// One-cycle registered output latency, one pair per cycle, no backpressure.
module huff_line_collector
  import mp3_huff_pkg::*;
#(
  parameter int LINES = GRANULE_LINES,
  parameter int VAL_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  huff_line_collector_if.slave bus
);

  localparam logic [9:0] LAST_IDX = 10'(LINES - 2);
  localparam logic [9:0] LINES_W  = 10'(LINES);

  coll_state_t             state_q, state_d;
  logic [8:0]              pair_cnt_q, pair_cnt_d;
  logic [8:0]              bv_q;
  logic [9:0]              r1_q, r2_q;
  huff_tbl_t               ts0_q, ts1_q, ts2_q;
  logic                    err_q, err_d;
  logic                    vld_q, vld_d;
  logic                    done_q, done_d;
  logic [9:0]              idx_q, idx_d;
  logic signed [VAL_W-1:0] x_q, x_d, y_q, y_d;

  logic                    latch;
  logic                    clamp;
  logic [8:0]              bv_clamped;
  logic [9:0]              line_cur;
  huff_tbl_t               region_tbl;

  // The pair counter keeps counting through FILL, so one line computation serves both states.
  assign line_cur = {pair_cnt_q, 1'b0};

  huff_region_sel u_region_sel (
    .line_num      (line_cur),
    .region1_start (r1_q),
    .region2_start (r2_q),
    .tbl0          (ts0_q),
    .tbl1          (ts1_q),
    .tbl2          (ts2_q),
    .tbl           (region_tbl)
  );

  always_comb begin
    state_d    = state_q;
    pair_cnt_d = pair_cnt_q;
    err_d      = err_q;
    vld_d      = 1'b0;
    done_d     = 1'b0;
    idx_d      = idx_q;
    x_d        = x_q;
    y_d        = y_q;
    latch      = 1'b0;
    clamp      = (bus.big_values > 9'(MAX_BIG_VALUES));
    bv_clamped = clamp ? 9'(MAX_BIG_VALUES) : bus.big_values;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          latch      = 1'b1;
          pair_cnt_d = '0;
          err_d      = clamp;
          state_d    = (bv_clamped != '0) ? BIG : FILL;
        end
        if (bus.axiiv) begin
          err_d = 1'b1;
        end
      end
      BIG: begin
        if (bus.axiiv) begin
          vld_d      = 1'b1;
          idx_d      = line_cur;
          x_d        = bus.x_val;
          y_d        = bus.y_val;
          done_d     = (line_cur == LAST_IDX);
          pair_cnt_d = pair_cnt_q + 9'd1;
          if (pair_cnt_q == bv_q - 9'd1) begin
            // A full-size region has no tail to fill.
            state_d = ({bv_q, 1'b0} == LINES_W) ? IDLE : FILL;
          end
        end
      end
      FILL: begin
        vld_d      = 1'b1;
        idx_d      = line_cur;
        x_d        = '0;
        y_d        = '0;
        pair_cnt_d = pair_cnt_q + 9'd1;
        if (line_cur == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        if (bus.axiiv) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pair_cnt_q <= '0;
      bv_q       <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      ts0_q      <= '0;
      ts1_q      <= '0;
      ts2_q      <= '0;
      err_q      <= 1'b0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      pair_cnt_q <= pair_cnt_d;
      err_q      <= err_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
      idx_q      <= idx_d;
      x_q        <= x_d;
      y_q        <= y_d;
      if (latch) begin
        bv_q  <= bv_clamped;
        r1_q  <= bus.region1_start;
        r2_q  <= bus.region2_start;
        ts0_q <= bus.table_select0;
        ts1_q <= bus.table_select1;
        ts2_q <= bus.table_select2;
      end
    end
  end

  assign bus.huff_en      = (state_q == BIG);
  assign bus.table_sel    = (state_q == BIG) ? region_tbl : ts0_q;
  assign bus.axiov        = vld_q;
  assign bus.line_idx     = idx_q;
  assign bus.x_out        = x_q;
  assign bus.y_out        = y_q;
  assign bus.granule_done = done_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_huff_line_collector.sv
// Self-checking bench for huff_line_collector: expected beats (line, data, done flag, cycle)
// are built per granule from the line-layout rules and compared beat by beat.
module tb_huff_line_collector;
  import mp3_huff_pkg::*;

  typedef struct {
    int idx;
    int x;
    int y;
    int done;
    int cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  beat_t exp_q[$];
  beat_t mb;

  int m_bv, m_r1, m_r2, m_t0, m_t1, m_t2, m_k, m_err, m_start_cyc, m_last_cyc;

  huff_line_collector_if #(.VAL_W(16)) bus ();

  huff_line_collector #(.LINES(576), .VAL_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_tbl(input int l);
    if (l < m_r1) return m_t0;
    if (l < m_r2) return m_t1;
    return m_t2;
  endfunction

  // Output monitor: every valid beat must match the head of the expected stream.
  always @(negedge clk) begin
    if (bus.axiov === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", int'(bus.line_idx), -1);
      end else begin
        mb = exp_q.pop_front();
        check("beat_idx", int'(bus.line_idx), mb.idx);
        check("beat_x", int'(bus.x_out), mb.x);
        check("beat_y", int'(bus.y_out), mb.y);
        check("beat_done", int'(bus.granule_done), mb.done);
        check("beat_cycle", cyc, mb.cyc);
      end
    end else if (bus.granule_done === 1'b1) begin
      check("done_without_beat", 1, 0);
    end
  end

  task automatic do_start(input int bv_raw, input int r1, input int r2,
                          input int t0, input int t1, input int t2);
    bus.start         = 1'b1;
    bus.big_values    = 9'(bv_raw);
    bus.region1_start = 10'(r1);
    bus.region2_start = 10'(r2);
    bus.table_select0 = 5'(t0);
    bus.table_select1 = 5'(t1);
    bus.table_select2 = 5'(t2);
    m_bv  = (bv_raw > 288) ? 288 : bv_raw;
    m_err = (bv_raw > 288) ? 1 : 0;
    m_r1 = r1; m_r2 = r2; m_t0 = t0; m_t1 = t1; m_t2 = t2;
    m_k = 0;
    m_start_cyc = cyc;
    tick();
    bus.start = 1'b0;
    check("err_after_start", int'(bus.err), m_err);
    check("huff_en_after_start", int'(bus.huff_en), (m_bv != 0) ? 1 : 0);
  endtask

  task automatic send_pair(input int gap, input int x, input int y, input bit inject);
    int l;
    repeat (gap) tick();
    l = 2 * m_k;
    check("table_sel", int'(bus.table_sel), exp_tbl(l));
    bus.axiiv = 1'b1;
    bus.x_val = 16'(x);
    bus.y_val = 16'(y);
    if (inject) begin
      bus.start         = 1'b1;
      bus.big_values    = 9'd1;
      bus.region1_start = 10'($urandom_range(0, 1023));
      bus.region2_start = 10'($urandom_range(0, 1023));
      bus.table_select0 = 5'($urandom_range(0, 31));
    end
    exp_q.push_back('{l, x, y, (l == 574) ? 1 : 0, cyc + 1});
    m_last_cyc = cyc;
    m_k++;
    tick();
    bus.axiiv = 1'b0;
    bus.start = 1'b0;
  endtask

  function automatic int rnd_val();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic finish_granule();
    int base;
    int en_seen;
    check("huff_en_after_big", int'(bus.huff_en), 0);
    base = (m_bv == 0) ? m_start_cyc + 2 : m_last_cyc + 2;
    for (int l = 2 * m_bv; l < 576; l += 2) begin
      exp_q.push_back('{l, 0, 0, (l == 574) ? 1 : 0, base + (l - 2 * m_bv) / 2});
    end
    en_seen = 0;
    for (int i = 0; i < 800 && exp_q.size() != 0; i++) begin
      tick();
      if (bus.huff_en === 1'b1) en_seen = 1;
    end
    check("drain_remaining", exp_q.size(), 0);
    exp_q.delete();
    check("huff_en_in_fill", en_seen, 0);
    check("err_at_end", int'(bus.err), m_err);
  endtask

  task automatic run_granule(input int bv_raw, input int max_gap, input int inject_at);
    int bv;
    do_start(bv_raw, $urandom_range(0, 600), $urandom_range(0, 600),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
    bv = m_bv;
    for (int k = 0; k < bv; k++) begin
      send_pair(($urandom_range(0, 3) == 0) ? $urandom_range(0, max_gap) : 0,
                rnd_val(), rnd_val(), k == inject_at);
    end
    finish_granule();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout got=%0d exp=0", cyc);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0; bus.big_values = '0; bus.region1_start = '0; bus.region2_start = '0;
    bus.table_select0 = '0; bus.table_select1 = '0; bus.table_select2 = '0;
    bus.axiiv = 1'b0; bus.x_val = '0; bus.y_val = '0;

    // Reset state
    repeat (2) tick();
    check("rst_axiov", int'(bus.axiov), 0);
    check("rst_done", int'(bus.granule_done), 0);
    check("rst_huff_en", int'(bus.huff_en), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_idx", int'(bus.line_idx), 0);
    check("rst_x", int'(bus.x_out), 0);
    check("rst_y", int'(bus.y_out), 0);
    check("rst_table_sel", int'(bus.table_sel), 0);
    rst_n = 1'b1;
    tick();

    // Regions and zero fill
    do_start(3, 2, 4, 3, 5, 7);
    send_pair(0, 1, -1, 1'b0);
    send_pair(0, 0, 2, 1'b0);
    send_pair(0, 15, 0, 1'b0);
    finish_granule();

    // Empty big_values region
    do_start(0, 10, 20, 1, 2, 3);
    check("bv0_table_sel", int'(bus.table_sel), 1);
    finish_granule();

    // Clamp with 288 back-to-back pairs
    run_granule(300, 0, -1);

    // Stray pair in IDLE
    bus.axiiv = 1'b1;
    bus.x_val = 16'sd5;
    bus.y_val = 16'sd6;
    tick();
    bus.axiiv = 1'b0;
    check("stray_err", int'(bus.err), 1);
    check("stray_no_beat", int'(bus.axiov), 0);
    tick();

    // start during BIG is ignored
    run_granule(20, 2, 7);

    // Reset mid-granule
    do_start(300, 100, 200, 4, 5, 6);
    for (int k = 0; k < 10; k++) send_pair(0, rnd_val(), rnd_val(), 1'b0);
    rst_n = 1'b0;
    tick();
    check("mrst_axiov", int'(bus.axiov), 0);
    check("mrst_done", int'(bus.granule_done), 0);
    check("mrst_huff_en", int'(bus.huff_en), 0);
    check("mrst_err", int'(bus.err), 0);
    check("mrst_idx", int'(bus.line_idx), 0);
    check("mrst_x", int'(bus.x_out), 0);
    check("mrst_y", int'(bus.y_out), 0);
    check("mrst_table_sel", int'(bus.table_sel), 0);
    check("mrst_pending", exp_q.size(), 0);
    exp_q.delete();
    rst_n = 1'b1;
    tick();
    run_granule(20, 1, -1);

    // Randomized granules
    for (int g = 0; g < 6; g++) begin
      run_granule($urandom_range(0, 320), 3, ($urandom_range(0, 1) == 1) ? 2 : -1);
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
